mem_stall_ctrl: RTL and testbench

Downstream consumer of the memory-instruction hazard logic in the 5-stage pipeline.
- Serialises LD/ST instructions: a memory op sitting in IF/ID is held while an older memory op is still draining through ID/EX, EX/MEM and MEM/WB.
- Freezes the whole pipeline while data memory reports busy.
- Drives the PC and IF/ID write enables and the ID/EX bubble select, and keeps a saturating stall-cycle performance counter.

---
 rtl/mem_stall_ctrl_pkg.sv | 19 +
 rtl/mem_stall_ctrl_sat_counter.sv | 23 ++
 rtl/mem_stall_ctrl.sv | 82 ++++++++
 tb/tb_mem_stall_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_stall_ctrl_pkg.sv
// Shared pipeline definitions for the memory-op hazard and stall logic.
package mem_stall_ctrl_pkg;

    localparam logic [4:0] OP_ST = 5'b10000;
    localparam logic [4:0] OP_LD = 5'b10001;

    localparam int unsigned DRAIN_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrain  = 2'd1,
        StFreeze = 2'd2
    } stall_state_e;

    function automatic logic is_mem_op(input logic [4:0] op, input logic valid);
        return valid && ((op == OP_ST) || (op == OP_LD));
    endfunction

endpackage

// File: rtl/mem_stall_ctrl_sat_counter.sv
// Saturating performance counter with synchronous reset; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mem_stall_ctrl.sv
// Serialises LD/ST issue behind a drain window, freezes the pipe on memory busy,
// and counts drain-stall cycles.
module mem_stall_ctrl
    import mem_stall_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_ifid_op,
    input  logic             i_ifid_valid,
    input  logic             i_flush,
    input  logic             i_mem_busy,
    output logic             o_pc_write_en,
    output logic             o_ifid_write_en,
    output logic             o_idex_bubble,
    output logic             o_pipe_freeze,
    output logic             o_stall_active,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam int unsigned CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);

    stall_state_e r_state;
    logic [CW-1:0] r_cnt;

    logic          w_mem_op;
    logic          w_draining;
    logic [CW-1:0] w_cnt_dec;

    assign w_mem_op   = is_mem_op(i_ifid_op, i_ifid_valid);
    // FREEZE with busy released resolves to IDLE/DRAIN purely by cnt.
    assign w_draining = (r_state != StIdle) && (r_cnt != '0);
    assign w_cnt_dec  = r_cnt - CW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else if (i_mem_busy) begin
            r_state <= StFreeze;
        end else if (!i_flush && w_mem_op && !w_draining) begin
            r_cnt   <= DRAIN_LOAD;
            r_state <= StDrain;
        end else if (w_draining) begin
            r_cnt   <= w_cnt_dec;
            r_state <= (w_cnt_dec != '0) ? StDrain : StIdle;
        end else begin
            r_state <= StIdle;
        end
    end

    always_comb begin
        o_pc_write_en   = 1'b1;
        o_ifid_write_en = 1'b1;
        o_idex_bubble   = 1'b0;
        o_pipe_freeze   = 1'b0;
        o_stall_active  = 1'b0;
        if (i_mem_busy) begin
            o_pipe_freeze   = 1'b1;
            o_pc_write_en   = 1'b0;
            o_ifid_write_en = 1'b0;
        end else if (!i_flush && w_mem_op && w_draining) begin
            o_pc_write_en   = 1'b0;
            o_ifid_write_en = 1'b0;
            o_idex_bubble   = 1'b1;
            o_stall_active  = 1'b1;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_inc  (o_stall_active),
        .o_count(o_stall_count)
    );

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Directed bench: two instances (16-bit and 4-bit counters) share stimulus.
module tb_mem_stall_ctrl;

    localparam logic [4:0] ST  = 5'b10000;
    localparam logic [4:0] LD  = 5'b10001;
    localparam logic [4:0] ADD = 5'b11011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ifid_op;
    logic        ifid_valid;
    logic        flush;
    logic        mem_busy;

    logic        pc_we, ifid_we, bubble, freeze, stall;
    logic [15:0] count;
    logic        s_pc_we, s_ifid_we, s_bubble, s_freeze, s_stall;
    logic [3:0]  s_count;

    typedef struct {
        string       tag;
        logic        pc, ifid, bub, frz, stl;
        logic [15:0] cnt;
        logic [3:0]  scnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mdl_cnt = 0;

    always #5 clk = ~clk;

    mem_stall_ctrl u_dut (
        .i_clk(clk), .i_rst(rst), .i_ifid_op(ifid_op), .i_ifid_valid(ifid_valid),
        .i_flush(flush), .i_mem_busy(mem_busy), .o_pc_write_en(pc_we),
        .o_ifid_write_en(ifid_we), .o_idex_bubble(bubble), .o_pipe_freeze(freeze),
        .o_stall_active(stall), .o_stall_count(count)
    );

    mem_stall_ctrl #(.CNT_W(4)) u_small (
        .i_clk(clk), .i_rst(rst), .i_ifid_op(ifid_op), .i_ifid_valid(ifid_valid),
        .i_flush(flush), .i_mem_busy(mem_busy), .o_pc_write_en(s_pc_we),
        .o_ifid_write_en(s_ifid_we), .o_idex_bubble(s_bubble), .o_pipe_freeze(s_freeze),
        .o_stall_active(s_stall), .o_stall_count(s_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, push its expectation, compare at negedge, advance past the edge.
    task automatic cyc(input string tag, input logic [4:0] op, input logic v, input logic fl,
                       input logic bz, input logic e_pc, input logic e_ifid, input logic e_bub,
                       input logic e_frz, input logic e_stl);
        exp_t e, g;
        ifid_op    = op;
        ifid_valid = v;
        flush      = fl;
        mem_busy   = bz;
        rst        = 1'b0;
        e.tag  = tag;
        e.pc   = e_pc;
        e.ifid = e_ifid;
        e.bub  = e_bub;
        e.frz  = e_frz;
        e.stl  = e_stl;
        e.cnt  = 16'(mdl_cnt);
        e.scnt = (mdl_cnt > 15) ? 4'hF : 4'(mdl_cnt);
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        chk({g.tag, ".pc_we"}, {31'd0, pc_we}, {31'd0, g.pc});
        chk({g.tag, ".ifid_we"}, {31'd0, ifid_we}, {31'd0, g.ifid});
        chk({g.tag, ".bubble"}, {31'd0, bubble}, {31'd0, g.bub});
        chk({g.tag, ".freeze"}, {31'd0, freeze}, {31'd0, g.frz});
        chk({g.tag, ".stall"}, {31'd0, stall}, {31'd0, g.stl});
        chk({g.tag, ".count"}, {16'd0, count}, {16'd0, g.cnt});
        chk({g.tag, ".s_stall"}, {31'd0, s_stall}, {31'd0, g.stl});
        chk({g.tag, ".s_count"}, {28'd0, s_count}, {28'd0, g.scnt});
        @(posedge clk);
        #1;
        if (e_stl) mdl_cnt++;
    endtask

    task automatic do_reset(input logic [4:0] op);
        ifid_op    = op;
        ifid_valid = 1'b1;
        flush      = 1'b0;
        mem_busy   = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mdl_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; ifid_op = '0; ifid_valid = 1'b0; flush = 1'b0; mem_busy = 1'b0;
        do_reset(ADD);
        do_reset(ADD);
        cyc("reset_idle", ADD, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 0);

        // Back-to-back LD then ST: three stall cycles then issue
        cyc("t1_ld_issue", LD, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc("t1_st_stall", ST, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1);
        cyc("t1_st_issue", ST, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);

        // Non-memory ops (and an invalid ST) drain the window unstalled
        cyc("t2_add0", ADD, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        cyc("t2_st_invalid", ST, 1'b0, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        cyc("t2_add2", ADD, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        cyc("t2_st_issue", ST, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);

        // ST waiting at cnt=2 through 4 busy cycles, then 2 more stalls and issue
        cyc("t3_stall_a", ST, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 4; i++) cyc("t3_busy", ST, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1, 0);
        cyc("t3_stall_b", ST, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1);
        cyc("t3_stall_c", ST, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1);
        cyc("t3_issue", ST, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);

        // Flush at cnt=2: no stall, cnt decrements; ADD drains the last cycle
        cyc("t4_stall", ST, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1);
        cyc("t4_flush", ST, 1'b1, 1'b1, 1'b0, 1, 1, 0, 0, 0);
        cyc("t4_add", ADD, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        cyc("t4_st_issue", ST, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);

        // Reset mid-drain clears cnt and stall_count
        cyc("t5_stall", ST, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1);
        do_reset(ADD);
        cyc("t5_ld_issue", LD, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);

        // Busy while idle-drained: FREEZE with cnt=0 then immediate issue
        for (int i = 0; i < 3; i++) cyc("t6_add", ADD, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        cyc("t6_busy", LD, 1'b1, 1'b0, 1'b1, 0, 0, 0, 1, 0);
        cyc("t6_ld_issue", LD, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);

        // 21 stall cycles: 4-bit counter saturates at F, 16-bit keeps counting
        for (int r = 0; r < 7; r++) begin
            for (int i = 0; i < 3; i++) cyc("t7_stall", LD, 1'b1, 1'b0, 1'b0, 0, 0, 1, 0, 1);
            cyc("t7_issue", LD, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        end
        cyc("t7_final", ADD, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 0);
        chk("t7_model_total", 32'(mdl_cnt), 32'd21);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
